// File: rtl/usart_frame_tx.sv
// usart_frame_tx: serialises a fixed 9-byte configuration frame over an 8N1
// UART line. The frame is FF, address, mode, three address-dependent payload
// bytes, two more payload bytes, then AA. A high idle gap follows the frame
// before the transmitter reports completion and accepts the next request.
module usart_frame_tx #(
  parameter logic [15:0] BPS_CNT   = 16'd434,
  parameter int          IDLE_BITS = 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [23:0] D,
  input  logic [1:0]  Adress,
  input  logic [5:0]  Mod_SEL,
  output logic        uart_txd,
  output logic        busy,
  output logic        send_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [15:0] BPS_LAST  = BPS_CNT - 16'd1;
  localparam logic [15:0] GAP_LAST  = 16'(IDLE_BITS - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd9;

  // Frame layout: byte index 1..9 selects the byte, address picks payload slots.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [1:0]  adr,
    input logic [5:0]  mode,
    input logic [23:0] data
  );
    logic [7:0] b;
    case (idx)
      4'd1:    b = 8'hFF;
      4'd2:    b = {6'b000000, adr};
      4'd3:    b = {2'b00, mode};
      4'd4:    b = (adr == 2'b00) ? data[23:16] : 8'h00;
      4'd5:    b = (adr == 2'b00) ? data[15:8]  : 8'h00;
      4'd6:    b = (adr == 2'b00) ? data[7:0]   : 8'h00;
      4'd7:    b = (adr == 2'b01) ? data[7:0]   : 8'h00;
      4'd8:    b = (adr == 2'b10) ? data[7:0]   : 8'h00;
      4'd9:    b = 8'hAA;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_t      r_state;
  logic [15:0] r_bps;
  logic [2:0]  r_bit_idx;
  logic [3:0]  r_byte_idx;
  logic [15:0] r_gap_cnt;
  logic [23:0] r_data;
  logic [1:0]  r_adr;
  logic [5:0]  r_mod;
  logic        r_txd;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  state_t      w_state_n;
  logic [15:0] w_bps_n;
  logic [2:0]  w_bit_n;
  logic [3:0]  w_byte_n;
  logic [15:0] w_gap_n;
  logic [23:0] w_data_n;
  logic [1:0]  w_adr_n;
  logic [5:0]  w_mod_n;
  logic        w_txd_n;
  logic        w_busy_n;
  logic        w_done_n;
  logic        w_err_n;

  logic        w_bps_wrap;
  logic [15:0] w_bps_inc;
  logic [2:0]  w_bit_inc;
  logic [7:0]  w_cur_byte;

  assign w_bps_wrap = (r_bps == BPS_LAST);
  assign w_bps_inc  = w_bps_wrap ? 16'd0 : (r_bps + 16'd1);
  assign w_bit_inc  = r_bit_idx + 3'd1;
  assign w_cur_byte = frame_byte(r_byte_idx, r_adr, r_mod, r_data);

  assign uart_txd  = r_txd;
  assign busy      = r_busy;
  assign send_done = r_done;
  assign err       = r_err;

  // Next-state, counter and next-output computation; line level is computed
  // for the next state so the registered output lines up with the state.
  always_comb begin
    w_state_n = r_state;
    w_bps_n   = r_bps;
    w_bit_n   = r_bit_idx;
    w_byte_n  = r_byte_idx;
    w_gap_n   = r_gap_cnt;
    w_data_n  = r_data;
    w_adr_n   = r_adr;
    w_mod_n   = r_mod;
    w_txd_n   = 1'b1;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bps_n = 16'd0;
        if (start && !r_busy && (Adress != 2'b11)) begin
          w_state_n = S_START;
          w_bit_n   = 3'd0;
          w_byte_n  = 4'd1;
          w_gap_n   = 16'd0;
          w_data_n  = D;
          w_adr_n   = Adress;
          w_mod_n   = Mod_SEL;
          w_txd_n   = 1'b0;
        end else if (start && !r_busy) begin
          w_err_n = 1'b1;
        end else begin
          w_err_n = 1'b0;
        end
      end
      S_START: begin
        w_bps_n = w_bps_inc;
        w_txd_n = 1'b0;
        if (w_bps_wrap) begin
          w_state_n = S_DATA;
          w_bit_n   = 3'd0;
          w_txd_n   = w_cur_byte[0];
        end else begin
          w_state_n = S_START;
        end
      end
      S_DATA: begin
        w_bps_n = w_bps_inc;
        w_txd_n = w_cur_byte[r_bit_idx];
        if (w_bps_wrap && (r_bit_idx == 3'd7)) begin
          w_state_n = S_STOP;
          w_bit_n   = 3'd0;
          w_txd_n   = 1'b1;
        end else if (w_bps_wrap) begin
          w_bit_n = w_bit_inc;
          w_txd_n = w_cur_byte[w_bit_inc];
        end else begin
          w_state_n = S_DATA;
        end
      end
      S_STOP: begin
        w_bps_n = w_bps_inc;
        w_txd_n = 1'b1;
        if (w_bps_wrap && (r_byte_idx == LAST_BYTE)) begin
          w_state_n = S_GAP;
          w_gap_n   = 16'd0;
        end else if (w_bps_wrap) begin
          // Next byte starts immediately: no idle between stop and start.
          w_state_n = S_START;
          w_byte_n  = r_byte_idx + 4'd1;
          w_txd_n   = 1'b0;
        end else begin
          w_state_n = S_STOP;
        end
      end
      S_GAP: begin
        w_bps_n = w_bps_inc;
        w_txd_n = 1'b1;
        if (w_bps_wrap && (r_gap_cnt == GAP_LAST)) begin
          w_state_n = S_IDLE;
          w_gap_n   = 16'd0;
          w_done_n  = 1'b1;
        end else if (w_bps_wrap) begin
          w_gap_n = r_gap_cnt + 16'd1;
        end else begin
          w_state_n = S_GAP;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_bps_n   = 16'd0;
        w_txd_n   = 1'b1;
      end
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

  // State, counters, latched request and registered outputs; reset wins over start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_bps      <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 4'd0;
      r_gap_cnt  <= 16'd0;
      r_data     <= 24'd0;
      r_adr      <= 2'd0;
      r_mod      <= 6'd0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_bps      <= w_bps_n;
      r_bit_idx  <= w_bit_n;
      r_byte_idx <= w_byte_n;
      r_gap_cnt  <= w_gap_n;
      r_data     <= w_data_n;
      r_adr      <= w_adr_n;
      r_mod      <= w_mod_n;
      r_txd      <= w_txd_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
    end
  end

endmodule
